// File: rtl/window_3x3_generator.sv
// 3x3 sliding-window generator for the median stage.
// Accepts a raster-order pixel stream, keeps the two previous rows in line
// buffers and presents a registered 3x3 neighbourhood for every fully
// interior position. o_enable_3x3 follows the accepting edge by one cycle.
module window_3x3_generator #(
  parameter int WIDTH      = 8,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic             i_sof,
  input  logic [WIDTH-1:0] i_pixel,
  output logic [WIDTH-1:0] o_pixel_00,
  output logic [WIDTH-1:0] o_pixel_01,
  output logic [WIDTH-1:0] o_pixel_02,
  output logic [WIDTH-1:0] o_pixel_10,
  output logic [WIDTH-1:0] o_pixel_11,
  output logic [WIDTH-1:0] o_pixel_12,
  output logic [WIDTH-1:0] o_pixel_20,
  output logic [WIDTH-1:0] o_pixel_21,
  output logic [WIDTH-1:0] o_pixel_22,
  output logic             o_enable_3x3,
  output logic             o_done
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_FILL  = RW'(1);
  localparam logic [CW-1:0] COL_FIRST = CW'(2);

  typedef enum logic {
    S_FILL   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            enable_q, enable_d;
  logic            done_q, done_d;

  // Window registers, index 3*row + column; column 2 is the newest entry.
  logic [WIDTH-1:0] win_q [0:8];
  logic [WIDTH-1:0] win_d [0:8];

  // Line buffers: lb0 holds row r-2, lb1 holds row r-1. Not reset; a full
  // refill of both rows always precedes the first emitted window.
  logic [WIDTH-1:0] lb0_q [0:IMG_WIDTH-1];
  logic [WIDTH-1:0] lb1_q [0:IMG_WIDTH-1];

  logic [CW-1:0]    cur_col;
  logic [RW-1:0]    cur_row;
  logic [WIDTH-1:0] lb0_rd;
  logic [WIDTH-1:0] lb1_rd;
  logic             last_pix;

  // Position of the pixel on the input this cycle (i_sof forces the origin)
  // and read-before-write line buffer taps at that column.
  always_comb begin
    cur_col  = i_sof ? '0 : col_q;
    cur_row  = i_sof ? '0 : row_q;
    lb0_rd   = lb0_q[cur_col];
    lb1_rd   = lb1_q[cur_col];
    last_pix = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
  end

  // Next-state: counters, FSM, window shift and the output strobes.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    enable_d = 1'b0;
    done_d   = 1'b0;
    for (int i = 0; i < 9; i++) win_d[i] = win_q[i];

    if (i_valid) begin
      // Raster counters with automatic frame wrap.
      if (cur_col == COL_LAST) begin
        col_d = '0;
        row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end

      // Every window row shifts left; new column enters on the right.
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb0_rd;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb1_rd;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = i_pixel;

      if (i_sof) begin
        state_d = S_FILL;
      end else begin
        unique case (state_q)
          S_FILL: begin
            if ((cur_row == ROW_FILL) && (cur_col == COL_LAST)) state_d = S_STREAM;
          end
          S_STREAM: begin
            // Columns 0 and 1 only prime the shift registers after a row wrap.
            enable_d = (cur_col >= COL_FIRST);
            done_d   = last_pix;
            if (last_pix) state_d = S_FILL;
          end
          default: state_d = S_FILL;
        endcase
      end
    end
  end

  // Control and window registers with asynchronous clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_FILL;
      col_q    <= '0;
      row_q    <= '0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      enable_q <= enable_d;
      done_q   <= done_d;
      for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
    end
  end

  // Line buffer update: the row moves from lb1 to lb0, the new pixel into lb1.
  always_ff @(posedge i_clk) begin
    if (i_valid) begin
      lb0_q[cur_col] <= lb1_rd;
      lb1_q[cur_col] <= i_pixel;
    end
  end

  assign o_pixel_00   = win_q[0];
  assign o_pixel_01   = win_q[1];
  assign o_pixel_02   = win_q[2];
  assign o_pixel_10   = win_q[3];
  assign o_pixel_11   = win_q[4];
  assign o_pixel_12   = win_q[5];
  assign o_pixel_20   = win_q[6];
  assign o_pixel_21   = win_q[7];
  assign o_pixel_22   = win_q[8];
  assign o_enable_3x3 = enable_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_window_3x3_generator.sv
// Scoreboard bench for window_3x3_generator on a 5x5 image.
module tb_window_3x3_generator;

  localparam int W  = 8;
  localparam int IW = 5;
  localparam int IH = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_sof = 1'b0;
  logic [W-1:0] i_pixel = '0;
  logic [W-1:0] p00, p01, p02, p10, p11, p12, p20, p21, p22;
  logic         o_en, o_done;

  window_3x3_generator #(.WIDTH(W), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_sof(i_sof), .i_pixel(i_pixel),
    .o_pixel_00(p00), .o_pixel_01(p01), .o_pixel_02(p02),
    .o_pixel_10(p10), .o_pixel_11(p11), .o_pixel_12(p12),
    .o_pixel_20(p20), .o_pixel_21(p21), .o_pixel_22(p22),
    .o_enable_3x3(o_en), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int strobes = 0;
  int dones = 0;
  logic acc_prev = 1'b0;

  // Expected entry: {nine pixels row-major oldest first, done}
  logic [9*W:0] exp_q [$];

  // Reference model: image indexed by position, plus the raster position.
  logic [W-1:0] img [0:IH-1][0:IW-1];
  int mr = 0;
  int mc = 0;

  function automatic void chk(input string name, input logic [9*W:0] act, input logic [9*W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void model_accept(input logic s, input logic [W-1:0] pix);
    logic [9*W:0] e;
    if (s) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = pix;
    if (mr >= 2 && mc >= 2) begin
      e = {img[mr-2][mc-2], img[mr-2][mc-1], img[mr-2][mc],
           img[mr-1][mc-2], img[mr-1][mc-1], img[mr-1][mc],
           img[mr][mc-2],   img[mr][mc-1],   img[mr][mc],
           (mr == IH-1 && mc == IW-1) ? 1'b1 : 1'b0};
      exp_q.push_back(e);
    end
    mc++;
    if (mc == IW) begin
      mc = 0;
      mr = (mr == IH-1) ? 0 : mr + 1;
    end
  endfunction

  task automatic send(input logic v, input logic s, input logic [W-1:0] pix);
    @(posedge clk);
    #1;
    i_valid = v;
    i_sof   = s;
    i_pixel = pix;
    if (v) model_accept(s, pix);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0, W'($urandom));
  endtask

  task automatic frame(input bit first_sof, input bit gaps, input bit rnd);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) begin
        if (gaps) while ($urandom_range(0, 1) == 1) send(1'b0, 1'b0, W'($urandom));
        send(1'b1, first_sof && r == 0 && c == 0, rnd ? W'($urandom) : W'(10*r + c));
      end
  endtask

  task automatic end_test(input string name, input int exp_strobes, input int exp_dones);
    idle(3);
    chk({name, "_strobes"}, (9*W+1)'(strobes), (9*W+1)'(exp_strobes));
    chk({name, "_dones"}, (9*W+1)'(dones), (9*W+1)'(exp_dones));
    chk({name, "_pending"}, (9*W+1)'(exp_q.size()), '0);
    exp_q.delete();
    strobes = 0;
    dones = 0;
  endtask

  task automatic check_zero(input string name);
    chk(name, {p00, p01, p02, p10, p11, p12, p20, p21, p22, o_done}, '0);
    chk({name, "_en"}, (9*W+1)'(o_en), '0);
  endtask

  // Records whether a pixel was accepted at each edge.
  always @(posedge clk) acc_prev <= i_valid;

  // Monitor: pops and compares whenever the DUT presents a window.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_done && !o_en) begin
        checks++;
        errors++;
        $display("FAIL done_without_enable: done=%b enable=%b", o_done, o_en);
      end
      if (o_en) begin
        strobes++;
        if (o_done) dones++;
        chk("strobe_after_accept", (9*W+1)'(acc_prev), (9*W+1)'(1));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got %h expected none",
                   {p00, p01, p02, p10, p11, p12, p20, p21, p22, o_done});
        end else begin
          chk("window", {p00, p01, p02, p10, p11, p12, p20, p21, p22, o_done}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #12;
    check_zero("reset_state");
    #10 rst_n = 1'b1;

    // Continuous stream with i_sof on the first pixel.
    frame(1'b1, 1'b0, 1'b0);
    end_test("continuous", 9, 1);

    // Same stream with random gaps.
    frame(1'b1, 1'b1, 1'b0);
    end_test("gaps", 9, 1);

    // Random pixel values and gaps.
    frame(1'b1, 1'b1, 1'b1);
    end_test("random", 9, 1);

    // Asynchronous reset after pixel 23, then a full frame without i_sof.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < IW; c++)
        if (r < 2 || c <= 3) send(1'b1, r == 0 && c == 0, W'(10*r + c));
    @(posedge clk);
    #1 i_valid = 1'b0;
    #6 rst_n = 1'b0;
    mr = 0;
    mc = 0;
    #1 check_zero("async_reset");
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    end_test("pre_reset", 2, 0);
    frame(1'b0, 1'b0, 1'b0);
    end_test("after_reset", 9, 1);

    // i_sof with value 99 at position (3,1) abandons the frame.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < IW; c++)
        if (r < 3 || c == 0) send(1'b1, r == 0 && c == 0, W'(10*r + c));
    send(1'b1, 1'b1, W'(99));
    for (int k = 1; k < IW*IH; k++) send(1'b1, 1'b0, W'(10*(k/IW) + (k%IW)));
    end_test("sof_abort", 12, 1);

    // Two back-to-back frames, i_sof only on the first.
    frame(1'b1, 1'b0, 1'b0);
    frame(1'b0, 1'b0, 1'b0);
    end_test("back_to_back", 18, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
